// File: rtl/lcd_texto_sequenciador.sv
`default_nettype none
// ============================================================================
// Module      : lcd_texto_sequenciador
// Description : Holds a 2x16 character shadow buffer and replays it to the
//               LCD_Controle driver on request: line-1 address command,
//               16 characters, line-2 address command, 16 characters.
//               The enable/busy handshake with the driver is owned here.
//               Optional macro AUTO_REFRESH_EN adds a periodic refresh timer.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_texto_sequenciador #(
    parameter int         CLK_FREQ   = 50,
    parameter int         REFRESH_MS = 100,
    parameter logic [7:0] LINE1_ADDR = 8'h80,
    parameter logic [7:0] LINE2_ADDR = 8'hC0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic       lcd_busy,
    output logic       lcd_enable,
    output logic [9:0] lcd_bus,
    output logic       seq_busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [5:0]  LAST_STEP   = 6'd33;
    localparam logic [5:0]  LINE2_STEP  = 6'd17;
    localparam logic [31:0] AUTO_PERIOD = 32'(CLK_FREQ * 1000 * REFRESH_MS);

    state_t     state_q, state_d;
    logic [5:0] step_q, step_d;
    logic       pending_q, pending_d;
    logic       lcd_enable_q, lcd_enable_d;
    logic [9:0] lcd_bus_q, lcd_bus_d;
    logic       seq_busy_q, seq_busy_d;
    logic       done_q, done_d;
    logic [7:0] char_q [32];

    logic       auto_tick;
    logic [4:0] char_idx;
    logic [9:0] issue_word;

`ifdef AUTO_REFRESH_EN
    logic [31:0] tick_cnt_q;

    // Free-running refresh timer; every wrap requests a refresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= 32'd0;
        end else if (tick_cnt_q == AUTO_PERIOD - 32'd1) begin
            tick_cnt_q <= 32'd0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    assign auto_tick = (tick_cnt_q == AUTO_PERIOD - 32'd1);
`else
    logic [31:0] period_unused;
    assign period_unused = AUTO_PERIOD;
    assign auto_tick     = 1'b0;
`endif

    // Shadow buffer: user writes land in any state, reset blanks the screen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                char_q[i] <= 8'h20;
            end
        end else if (wr_en) begin
            char_q[wr_addr] <= wr_data;
        end
    end

    // Step-to-buffer mapping: steps 1-16 read 0-15, steps 18-33 read 16-31
    // (the 5-bit subtraction wraps steps 32/33 onto entries 30/31)
    always_comb begin
        char_idx = (step_q <= 6'd16) ? (step_q[4:0] - 5'd1) : (step_q[4:0] - 5'd2);
        if (step_q == 6'd0) begin
            issue_word = {2'b00, LINE1_ADDR};
        end else if (step_q == LINE2_STEP) begin
            issue_word = {2'b00, LINE2_ADDR};
        end else begin
            issue_word = {2'b10, char_q[char_idx]};
        end
    end

    // State, step, pending flag and registered driver outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_q       <= 6'd0;
            pending_q    <= 1'b1;
            lcd_enable_q <= 1'b0;
            lcd_bus_q    <= 10'd0;
            seq_busy_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            pending_q    <= pending_d;
            lcd_enable_q <= lcd_enable_d;
            lcd_bus_q    <= lcd_bus_d;
            seq_busy_q   <= seq_busy_d;
            done_q       <= done_d;
        end
    end

    // Sequencer next-state logic and the handshake with the driver
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        pending_d    = pending_q;
        lcd_enable_d = 1'b0;
        lcd_bus_d    = lcd_bus_q;
        seq_busy_d   = seq_busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                seq_busy_d = 1'b0;
                if (pending_q) begin
                    pending_d  = 1'b0;
                    step_d     = 6'd0;
                    seq_busy_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!lcd_busy) begin
                    lcd_enable_d = 1'b1;
                    lcd_bus_d    = issue_word;
                    state_d      = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!lcd_busy) begin
                    if (step_q == LAST_STEP) begin
                        done_d     = 1'b1;
                        seq_busy_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New content or an explicit request always earns one more replay
        if (wr_en || refresh || auto_tick) begin
            pending_d = 1'b1;
        end
    end

    assign lcd_enable = lcd_enable_q;
    assign lcd_bus    = lcd_bus_q;
    assign seq_busy   = seq_busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_texto_sequenciador.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_texto_sequenciador
// Description : Self-checking bench for lcd_texto_sequenciador with an LCD
//               driver model and a character-buffer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_texto_sequenciador;

    localparam logic [7:0] L1 = 8'h80;
    localparam logic [7:0] L2 = 8'hC0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic       refresh = 1'b0;
    logic       lcd_busy;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       seq_busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    lcd_texto_sequenciador dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .refresh    (refresh),
        .lcd_busy   (lcd_busy),
        .lcd_enable (lcd_enable),
        .lcd_bus    (lcd_bus),
        .seq_busy   (seq_busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Driver model: busy rises the cycle after enable and stays up a few cycles
    logic force_busy = 1'b1;
    int   drv_cnt    = 0;
    bit   drv_rand   = 1'b0;
    assign lcd_busy = force_busy || (drv_cnt != 0);

    always @(posedge clk) begin
        if (lcd_enable) begin
            drv_cnt <= drv_rand ? int'($urandom_range(6, 1)) : 5;
        end else if (drv_cnt != 0) begin
            drv_cnt <= drv_cnt - 1;
        end
    end

    // Monitor: record every strobe and note protocol violations
    logic [9:0] rx[$];
    int         done_cnt  = 0;
    int         viol      = 0;
    logic       prev_en   = 1'b0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        if (lcd_enable) begin
            rx.push_back(lcd_bus);
            if (lcd_busy) viol++;
            if (prev_en) viol++;
        end
        if (done) begin
            done_cnt++;
            if (prev_done) viol++;
        end
        prev_en   = lcd_enable;
        prev_done = done;
    end

    // Reference model: the screen contents and the replay they imply
    logic [7:0] mbuf [32];
    logic [9:0] exp_q[$];

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back({2'b00, L1});
        for (int i = 0; i < 16; i++) exp_q.push_back({2'b10, mbuf[i]});
        exp_q.push_back({2'b00, L2});
        for (int i = 16; i < 32; i++) exp_q.push_back({2'b10, mbuf[i]});
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int base);
        logic [31:0] obs;
        build_exp();
        for (int i = 0; i < 34; i++) begin
            obs = (base + i < rx.size()) ? 32'(rx[base + i]) : 32'hFFFF_FFFF;
            chk($sformatf("%s[%0d]", tag, i), obs, 32'(exp_q[i]));
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int c = 0;
        while (done_cnt < n && c < budget) begin
            tick();
            c++;
        end
        chk("done_count", done_cnt, n);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rx.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("strobe_count", rx.size(), n);
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        int c = 0;
        while (q < 5 && c < budget) begin
            tick();
            if (!seq_busy) q++; else q = 0;
            c++;
        end
        chk("quiet", (q >= 5), 1);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        mbuf[a] = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic clear_obs();
        rx.delete();
        done_cnt = 0;
    endtask

    task automatic blank_model();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string hello;
        string world;
        logic [4:0] a;
        hello = "HELLO";
        world = "WORLD";
        blank_model();

        // Reset values
        #1;
        chk("rst_enable", lcd_enable, 0);
        chk("rst_bus", lcd_bus, 0);
        chk("rst_seq_busy", seq_busy, 0);
        chk("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b0;

        // Driver still powering up: nothing may be issued
        repeat (100) tick();
        chk("powerup_no_enable", rx.size(), 0);
        chk("powerup_seq_busy", seq_busy, 1);
        force_busy = 1'b0;
        wait_done(1, 2000);
        chk("blank_len", rx.size(), 34);
        check_seq("blank", 0);
        wait_quiet(1000);
        chk("blank_single_done", done_cnt, 1);

        // HELLO / WORLD, then an explicit refresh with latency check
        for (int i = 0; i < 5; i++) do_write(5'(i), hello[i]);
        for (int i = 0; i < 5; i++) do_write(5'(16 + i), world[i]);
        wait_quiet(5000);
        clear_obs();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        chk("lat_cycle1", lcd_enable, 0);
        tick();
        chk("lat_cycle2", lcd_enable, 0);
        tick();
        chk("lat_cycle3", lcd_enable, 1);
        wait_done(1, 1000);
        chk("hello_len", rx.size(), 34);
        check_seq("hello", 0);
        wait_quiet(1000);
        chk("hello_single_done", done_cnt, 1);

        // Random contents with a randomly timed driver
        drv_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(8, 1));
            for (int k = 0; k < n; k++) begin
                do_write(5'($urandom_range(31, 0)), 8'($urandom_range(8'h7E, 8'h21)));
            end
            wait_quiet(5000);
            clear_obs();
            pulse_refresh();
            wait_done(1, 1000);
            check_seq($sformatf("rand%0d", r), 0);
            wait_quiet(1000);
            chk("rand_single_done", done_cnt, 1);
        end
        drv_rand = 1'b0;

        // Write late-issued entries while step 5 is in flight
        clear_obs();
        pulse_refresh();
        wait_rx(6, 500);
        do_write(5'd31, 8'h41);
        a = 5'($urandom_range(30, 21));
        do_write(a, 8'($urandom_range(8'h7E, 8'h21)));
        wait_done(2, 2000);
        chk("midwrite_len", rx.size(), 68);
        chk("midwrite_step33", (rx.size() > 33) ? 32'(rx[33]) : 32'hFFFF_FFFF, 32'h241);
        check_seq("midwrite_a", 0);
        check_seq("midwrite_b", 34);
        wait_quiet(1000);

        // Driver stalls inside the wait for step 10 to complete
        clear_obs();
        pulse_refresh();
        wait_rx(11, 500);
        force_busy = 1'b1;
        repeat (200) tick();
        chk("stall_no_enable", rx.size(), 11);
        force_busy = 1'b0;
        tick();
        chk("stall_release1", lcd_enable, 0);
        tick();
        chk("stall_release2", lcd_enable, 1);
        wait_done(1, 1000);
        chk("stall_len", rx.size(), 34);
        check_seq("stall", 0);
        wait_quiet(1000);

        // Reset in the middle of a sequence
        clear_obs();
        pulse_refresh();
        wait_rx(21, 1000);
        rst = 1'b1;
        #1;
        chk("midrst_enable", lcd_enable, 0);
        chk("midrst_seq_busy", seq_busy, 0);
        chk("midrst_bus", lcd_bus, 0);
        tick();
        rst = 1'b0;
        blank_model();
        clear_obs();
        wait_done(1, 2000);
        chk("midrst_len", rx.size(), 34);
        check_seq("midrst", 0);
        wait_quiet(1000);

        // No further sequence without a request
        clear_obs();
        repeat (3000) tick();
        chk("idle_no_strobe", rx.size(), 0);
        chk("idle_no_done", done_cnt, 0);

        chk("protocol_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_texto_sequenciador.md
Name: lcd_texto_sequenciador

Overview:
Sequencer that sits between user logic and the LCD_Controle driver and owns its lcd_enable/lcd_bus/busy handshake. It holds a 32-character shadow buffer (2 lines x 16) that user logic writes at any time. On a refresh request it replays the whole buffer to the display: set-DDRAM-address command, 16 characters, second address command, 16 characters.

Parameters:
CLK_FREQ, 50, main clock in MHz (only used by the optional feature)
REFRESH_MS, 100, auto-refresh period in ms (only used by the optional feature)
LINE1_ADDR, 8'h80, set-DDRAM command for line 1
LINE2_ADDR, 8'hC0, set-DDRAM command for line 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
wr_en  input  1  buffer write strobe
wr_addr  input  5  character index; 0-15 is line 1, 16-31 is line 2
wr_data  input  8  character code
refresh  input  1  request a full display refresh (single-cycle pulse or level)
lcd_busy  input  1  busy from the LCD driver
lcd_enable  output  1  one-cycle command strobe to the driver
lcd_bus  output  10  {rs, rw, data[7:0]} to the driver
seq_busy  output  1  high while a refresh sequence is in progress
done  output  1  one-cycle pulse when the last character of a sequence completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Values during reset:
  - lcd_enable=0, lcd_bus=0, seq_busy=0, done=0.
  - All 32 buffer entries = 8'h20 (space).
  - step=0, state=IDLE.
  - pending=1, so a blank-screen refresh runs once the driver is ready.
- Buffer writes:
  - Writes land every cycle that wr_en=1, in any state.
  - A write sets pending=1.
  - A write issued during a refresh updates the buffer immediately. The ongoing sequence is not restarted; the write set pending, so one more refresh follows.
- refresh=1 sets pending=1. Repeated requests while pending is already set collapse into a single pending flag.
- Step counter `step` runs 0..33:
  - step 0: command LINE1_ADDR, bus = {1'b0, 1'b0, LINE1_ADDR}.
  - steps 1-16: characters buf[0..15], bus = {1'b1, 1'b0, buf[step-1]}.
  - step 17: command LINE2_ADDR.
  - steps 18-33: characters buf[16..31], bus = {1'b1, 1'b0, buf[step-2]}.
- The character is sampled from the buffer when it is issued (ISSUE state), not when the refresh starts.
- States:
  - IDLE: seq_busy=0, lcd_enable=0. If pending=1: clear pending, step=0, seq_busy=1, go to ISSUE.
  - ISSUE: wait until lcd_busy=0. In that cycle drive lcd_bus for the current step and lcd_enable=1 for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: lcd_enable=0, lcd_bus held. Stay until lcd_busy=1 (the driver raises it the cycle after it accepts), then go to WAIT_DONE.
  - WAIT_DONE: stay until lcd_busy=0. Then:
    - if step=33: pulse done=1 for one cycle and go to IDLE (seq_busy=0 on that same edge);
    - otherwise step+1 and go to ISSUE.
- Latency: the earliest lcd_enable comes 2 cycles after refresh is sampled in IDLE, provided lcd_busy=0.
- lcd_enable is never asserted while lcd_busy=1, and never on two consecutive cycles.
- Before the driver finishes its power-on (lcd_busy=1 for about 52 ms), the block waits in ISSUE indefinitely. There is no timeout.
- A pending flag set during a sequence starts the next sequence directly from IDLE on the cycle after done.
- Reset mid-sequence: everything returns to the reset values immediately. The driver may still finish its current command; the block waits in ISSUE for lcd_busy=0 before issuing anything.
- wr_en and refresh in the same cycle: the write is applied and a single pending flag is set.

Optional Feature:
Macro: AUTO_REFRESH_EN
- Defined: a free-running counter of CLK_FREQ*1000*REFRESH_MS cycles (32-bit). Each time it wraps, pending=1. The counter resets to 0 on rst.
- Not defined: the counter is absent; refreshes happen only through refresh, buffer writes, or the initial post-reset pending.

Test Plan:
- Reset, then hold lcd_busy=1 for 100 cycles, then release it. Use a driver model that raises busy 1 cycle after enable and holds it 5 cycles. -> 34 lcd_enable strobes: first bus=10'h080, then 16 x 10'h220, then 10'h0C0, then 16 x 10'h220; one done pulse.
- Write "HELLO" to addresses 0-4 and "WORLD" to 16-20, let the sequence finish, then pulse refresh. -> characters sent: 10'h248,10'h245,10'h24C,10'h24C,10'h24F, then spaces, 10'h0C0, then 10'h257,...; done once.
- Write addr 31=8'h41 while step=5. -> the current sequence sends 10'h241 at step 33; a second full sequence starts immediately after done; 2 done pulses in total.
- lcd_busy held high for 200 cycles inside WAIT_DONE at step 10. -> no lcd_enable during that time; step 11 is issued 2 cycles after busy falls; lcd_enable width is always 1.
- Assert rst at step 20. -> lcd_enable=0, seq_busy=0 and buffer back to spaces in the same cycle; after release a full blank sequence runs.
- With AUTO_REFRESH_EN, CLK_FREQ=1, REFRESH_MS=1 and a fast driver model. -> a new sequence starts every 1000 cycles with no refresh input; without the macro, no sequence starts after the first.
